// File: rtl/mux_pipe_arb_if.sv
// mux_pipe_arb_if: producer/consumer bundle for the mux_pipe_arb selector.
// Ports: in_data/in_valid/in_ready (producers), sig (select), out/out_valid/out_ready/out_src (consumer).
interface mux_pipe_arb_if #(
    parameter int WIDTH = 64,
    parameter int N_IN  = 4,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
);
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [SEL_W-1:0]      sig;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_src;

    modport master (
        output in_data,
        output in_valid,
        output sig,
        output out_ready,
        input  in_ready,
        input  out,
        input  out_valid,
        input  out_src
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  sig,
        input  out_ready,
        output in_ready,
        output out,
        output out_valid,
        output out_src
    );
endinterface

// File: rtl/mux_pipe_arb.sv
// mux_pipe_arb: registered N:1 selector with valid/ready per input, explicit or round-robin pick.
// Ports: clk, rst (sync, active-high), bus (slave side of mux_pipe_arb_if).
module mux_pipe_arb #(
    parameter int WIDTH = 64,
    parameter int N_IN  = 4,
    parameter int MODE  = 0,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    mux_pipe_arb_if.slave bus
);

    if (N_IN < 2 || N_IN > 16) begin : g_bad_n
        $error("mux_pipe_arb: N_IN out of range");
    end

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_src;
    logic [SEL_W-1:0] r_ptr;

    logic             w_ld;
    logic             w_hit;
    logic             w_hit_lo;
    logic             w_hit_hi;
    logic [SEL_W-1:0] w_idx_lo;
    logic [SEL_W-1:0] w_idx_hi;
    logic [SEL_W-1:0] w_gidx;
    logic [N_IN-1:0]  w_grant;
    logic [N_IN-1:0]  w_rdy;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic [SEL_W-1:0] w_ptr_nxt;

    // Output stage can take an item when empty or draining this cycle.
    assign w_ld = !r_out_valid || bus.out_ready;

    // Round-robin search split in two: the lowest valid index at or above
    // ptr wins; failing that, the lowest valid index below ptr (wrap).
    // Descending loops leave the lowest matching index in the result.
    always_comb begin
        w_hit_lo = 1'b0;
        w_hit_hi = 1'b0;
        w_idx_lo = '0;
        w_idx_hi = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                if (SEL_W'(i) < r_ptr) begin
                    w_hit_lo = 1'b1;
                    w_idx_lo = SEL_W'(i);
                end else begin
                    w_hit_hi = 1'b1;
                    w_idx_hi = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_hit  = 1'b0;
        w_gidx = '0;
        if (MODE == 0) begin
            // Out-of-range select grants nobody.
            w_hit  = {1'b0, bus.sig} < (SEL_W + 1)'(N_IN);
            w_gidx = bus.sig;
        end else if (w_hit_hi) begin
            w_hit  = 1'b1;
            w_gidx = w_idx_hi;
        end else if (w_hit_lo) begin
            w_hit  = 1'b1;
            w_gidx = w_idx_lo;
        end
    end

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_grant[i] = w_hit && (w_gidx == SEL_W'(i));
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_grant[i]) begin
                w_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset masks ready so producers never see a handshake that is discarded.
    assign w_rdy     = w_grant & {N_IN{w_ld && !rst}};
    assign w_xfer    = |(bus.in_valid & w_rdy);
    assign w_ptr_nxt = (w_gidx == SEL_W'(N_IN - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out       <= w_data;
                r_out_src   <= w_gidx;
                r_out_valid <= 1'b1;
                if (MODE != 0) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_rdy;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;

endmodule

// File: doc/mux_pipe_arb.md
Name: mux_pipe_arb

Overview:
- Parametrised, registered N:1 datapath selector: next generation of the combinational 2:1 64-bit mux.
- Adds per-input valid/ready handshake, a one-entry output register stage, and a round-robin arbitration mode.
- Used in the pipeline wherever multiple producers share one consumer, such as writeback source select and forwarding paths.
- Mode 0 keeps explicit-select semantics (`sig`). Mode 1 arbitrates among valid inputs.

Parameters:
- WIDTH, 64, data width of each input and of the output.
- N_IN, 4, number of inputs; legal range 2..16.
- MODE, 0, 0 = select by `sig`; 1 = round-robin arbitration, `sig` ignored.
- SEL_W, max(1,$clog2(N_IN)), width of `sig` and `out_src`; derived, do not override.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-input valid.
- in_ready  output  N_IN  per-input ready, combinational.
- sig  input  SEL_W  input select (MODE 0 only).
- out  output  WIDTH  registered selected data.
- out_valid  output  1  `out` holds a valid item.
- out_ready  input  1  consumer accepts `out` this cycle.
- out_src  output  SEL_W  index of the input that produced `out`.

Behaviour:
- Reset: applied on a clk edge with `rst`=1. `out`=0, `out_valid`=0, `out_src`=0, round-robin pointer `ptr`=0.
  - Reset overrides any transfer in the same cycle.
  - An item held in the output register is dropped; no partial state survives.
- Load enable: `ld` = !`out_valid` || `out_ready`. The output stage accepts a new item whenever it is empty or being drained this cycle, giving full throughput of 1 item/cycle.
- Grant vector `g[N_IN-1:0]` (combinational, one-hot or zero):
  - MODE 0: `g[sig]`=1 when `sig` < N_IN; otherwise `g`=0, so no input is ever accepted.
  - MODE 1: the first i with `in_valid[i]`=1, searching `ptr`, `ptr`+1, …, `ptr`+N_IN-1 mod N_IN. `g`=0 if no input is valid.
- `in_ready[i]` = `g[i]` && `ld`.
  - In MODE 0, `in_ready[sig]` may be 1 while `in_valid[sig]`=0; no transfer happens.
  - `in_ready` must not depend on `in_valid[i]` in MODE 0. In MODE 1 it depends on `in_valid` through `g`.
- Transfer on input i: `in_valid[i]` && `in_ready[i]` at a clk edge. At that edge:
  - `out` <= in_data slice i;
  - `out_src` <= i;
  - `out_valid` <= 1.
- No transfer and `out_ready`=1: `out_valid` <= 0. `out` and `out_src` hold their last values.
- Stall: `out_valid`=1 and `out_ready`=0. `out`, `out_src` and `out_valid` hold; all `in_ready`=0.
- Latency: exactly 1 cycle from input transfer to `out_valid`=1.
- Simultaneous drain and load: the old item leaves and the new one is captured on the same edge; no bubble.
- Round-robin pointer (MODE 1 only):
  - On a transfer from input i, `ptr` <= (i+1) mod N_IN, wrapping from N_IN-1 to 0.
  - `ptr` is unchanged when nothing transfers.
  - Guarantees each persistently valid input is granted within N_IN transfers.
- MODE 0: `ptr` is unused and stays 0.
- Changing `sig` while stalled is legal; the held output is unaffected.
- Data passes through unmodified. There is no width conversion or sign extension.

Test Plan:
- Reset, then release:
  - `rst`=1 for 2 cycles with all inputs valid → `out`=0, `out_valid`=0, `out_src`=0, `in_ready`=0 while `rst`=1.
  - First transfer occurs on the first edge after `rst`=0.
- MODE 0 select, WIDTH=64, N_IN=4:
  - Inputs: in0=0x0, in1=0xFFFFFFFFFFFFFFFF, in2=0x0123456789ABCDEF, in3=0xDEADBEEFCAFEF00D; all valid; `out_ready`=1.
  - Stimulus: `sig`=0,1,2,3 on consecutive cycles.
  - Expected: `out` shows those four values, one cycle later each, with `out_src`=0,1,2,3 and `out_valid` continuously 1.
- MODE 0 backpressure:
  - After in2 is captured, hold `out_ready`=0 for 3 cycles while switching `sig` to 3.
  - Expected: `out` stays 0x0123456789ABCDEF and all `in_ready`=0.
  - Then raise `out_ready`=1 → in3 is captured next edge; no item is lost or duplicated.
- MODE 0 out-of-range select (N_IN=3, SEL_W=2):
  - Stimulus: `sig`=3 with all inputs valid.
  - Expected: `in_ready`=0; `out_valid` falls to 0 after the pending item drains.
- MODE 1 round-robin fairness, N_IN=4, all inputs always valid, `out_ready`=1:
  - Expected `out_src` sequence: 0,1,2,3,0,1 (pointer wrap-around).
  - Then with only in2 and in0 valid: grants alternate 2,0,2,0.
- Reset mid-operation:
  - Assert `rst` while `out_valid`=1 and `out_ready`=0 → next edge gives `out_valid`=0, `out`=0, `ptr`=0.
  - After release in MODE 1 with all inputs valid, the first `out_src`=0.
